// File: rtl/if_fetch_buffer.sv
// Instruction-fetch front end: issues one imem read per PC, queues returned
// instructions with their PCs in a 2-entry FIFO and drives the PC stall.
module if_fetch_buffer #(
   parameter int            W        = 32,
   parameter logic [W-1:0]  RESET_PC = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [W-1:0]  pc,
   input  logic          flush,
   output logic          pc_stall,
   output logic          imem_req_valid,
   output logic [W-1:0]  imem_req_addr,
   input  logic          imem_req_ready,
   input  logic          imem_resp_valid,
   input  logic [W-1:0]  imem_resp_data,
   output logic          id_valid,
   output logic [W-1:0]  id_inst,
   output logic [W-1:0]  id_pc,
   input  logic          id_ready
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DROP = 2'd2;

   logic [1:0]    r_state;
   logic [1:0]    w_state_nxt;
   logic [1:0]    r_count;
   logic          r_wptr;
   logic          r_rptr;
   logic [W-1:0]  r_inst [2];
   logic [W-1:0]  r_pc   [2];
   logic [W-1:0]  r_req_pc;

   logic          w_req_valid;
   logic          w_fire;
   logic          w_push;
   logic          w_pop;

   // Same-cycle reissue from WAIT only when the FIFO is empty, so a push can never overflow.
   assign w_req_valid = rst && !flush &&
                        ((r_state == S_IDLE && r_count < 2'd2) ||
                         (r_state == S_WAIT && imem_resp_valid && r_count == 2'd0));
   assign w_fire = w_req_valid && imem_req_ready;
   assign w_push = (r_state == S_WAIT) && imem_resp_valid && !flush;
   assign w_pop  = id_valid && id_ready && !flush;

   assign imem_req_valid = w_req_valid;
   assign imem_req_addr  = pc;
   assign pc_stall       = !rst || (!w_fire && !flush);

   assign id_valid = (r_count != 2'd0);
   assign id_inst  = r_inst[r_rptr];
   assign id_pc    = r_pc[r_rptr];

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_fire) w_state_nxt = S_WAIT;
         S_WAIT: begin
            if (flush)
               w_state_nxt = imem_resp_valid ? S_IDLE : S_DROP;
            else if (imem_resp_valid)
               w_state_nxt = w_fire ? S_WAIT : S_IDLE;
         end
         S_DROP: if (imem_resp_valid) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_count   <= 2'd0;
         r_wptr    <= 1'b0;
         r_rptr    <= 1'b0;
         r_inst[0] <= '0;
         r_inst[1] <= '0;
         r_pc[0]   <= RESET_PC;
         r_pc[1]   <= RESET_PC;
      end else begin
         r_state <= w_state_nxt;
         if (flush) begin
            r_count <= 2'd0;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
         end else begin
            if (w_push) begin
               r_inst[r_wptr] <= imem_resp_data;
               r_pc[r_wptr]   <= r_req_pc;
               r_wptr         <= ~r_wptr;
            end
            if (w_pop)
               r_rptr <= ~r_rptr;
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + 2'd1;
               2'b01:   r_count <= r_count - 2'd1;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   // PC of the outstanding request; only meaningful while a request is in flight.
   always_ff @(posedge clk) begin
      if (w_fire)
         r_req_pc <= pc;
   end

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Directed bench for if_fetch_buffer with a PC-register model, a latency-programmable
// instruction memory model and a scoreboard of expected {pc, inst} deliveries.
module tb_if_fetch_buffer;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [31:0]  pc = '0;
   logic         flush = 1'b0;
   logic         pc_stall;
   logic         imem_req_valid;
   logic [31:0]  imem_req_addr;
   logic         imem_req_ready = 1'b1;
   logic         imem_resp_valid = 1'b0;
   logic [31:0]  imem_resp_data = '0;
   logic         id_valid;
   logic [31:0]  id_inst;
   logic [31:0]  id_pc;
   logic         id_ready = 1'b1;

   if_fetch_buffer #(.W(32), .RESET_PC(32'h0)) dut (
      .clk             (clk),
      .rst             (rst),
      .pc              (pc),
      .flush           (flush),
      .pc_stall        (pc_stall),
      .imem_req_valid  (imem_req_valid),
      .imem_req_addr   (imem_req_addr),
      .imem_req_ready  (imem_req_ready),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .id_valid        (id_valid),
      .id_inst         (id_inst),
      .id_pc           (id_pc),
      .id_ready        (id_ready)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   typedef struct {
      logic [31:0] addr;
      int          due;
      bit          drop;
   } pend_t;

   ent_t         exp_q [$];
   pend_t        pend_q [$];
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   int           lat = 1;
   logic [31:0]  flush_tgt = '0;
   logic [31:0]  cur_addr = '0;
   bit           cur_drop = 1'b1;

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return 32'h24010001 + a;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at the negedge: sample the DUT, update models, cross the posedge.
   task automatic adv();
      bit           s_fire, s_stall, s_pop, s_flush;
      logic [31:0]  s_addr;
      ent_t         e;
      pend_t        p;
      s_fire  = imem_req_valid && imem_req_ready;
      s_addr  = imem_req_addr;
      s_stall = pc_stall;
      s_pop   = id_valid && id_ready;
      s_flush = flush;
      chk("id_valid_vs_model", {31'b0, id_valid}, {31'b0, exp_q.size() != 0});
      if (s_flush) begin
         exp_q.delete();
         foreach (pend_q[i]) pend_q[i].drop = 1'b1;
      end else begin
         if (s_pop && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_id_pc", id_pc, e.pc);
            chk("sb_id_inst", id_inst, e.inst);
         end
         if (imem_resp_valid && !cur_drop) begin
            e.pc   = cur_addr;
            e.inst = imem_resp_data;
            exp_q.push_back(e);
         end
      end
      if (s_fire) begin
         p.addr = s_addr;
         p.due  = cyc + lat;
         p.drop = 1'b0;
         pend_q.push_back(p);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (s_flush)
         pc = flush_tgt;
      else if (!s_stall)
         pc = pc + 32'd4;
      flush = 1'b0;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
         p = pend_q.pop_front();
         imem_resp_valid = 1'b1;
         imem_resp_data  = mdata(p.addr);
         cur_addr        = p.addr;
         cur_drop        = p.drop;
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = '0;
         cur_drop        = 1'b1;
      end
   endtask

   task automatic do_reset(input logic [31:0] start_pc);
      rst = 1'b0;
      flush = 1'b0;
      exp_q.delete();
      pend_q.delete();
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      cur_drop = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
      chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      chk("rst_pc_stall", {31'b0, pc_stall}, 32'd1);
      chk("rst_id_pc", id_pc, 32'h0);
      chk("rst_id_inst", id_inst, 32'h0);
      pc  = start_pc;
      rst = 1'b1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         adv();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;

      // 1: basic fetch with 1-cycle memory
      imem_req_ready = 1'b1; id_ready = 1'b1; lat = 1;
      do_reset(32'h0);
      @(negedge clk);
      chk("t1_c1_req_valid", {31'b0, imem_req_valid}, 32'd1);
      chk("t1_c1_pc_stall", {31'b0, pc_stall}, 32'd0);
      chk("t1_c1_addr", imem_req_addr, 32'h0);
      adv();
      @(negedge clk);
      chk("t1_c2_reissue", {31'b0, imem_req_valid}, 32'd1);
      chk("t1_c2_addr", imem_req_addr, 32'h4);
      adv();
      @(negedge clk);
      chk("t1_c3_id_valid", {31'b0, id_valid}, 32'd1);
      chk("t1_c3_id_pc", id_pc, 32'h0);
      chk("t1_c3_id_inst", id_inst, 32'h24010001);
      adv();
      run(8);

      // 2: ID stalled, FIFO fills, third request held
      id_ready = 1'b0; lat = 1;
      do_reset(32'h0);
      run(3);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t2_full_req_valid", {31'b0, imem_req_valid}, 32'd0);
         chk("t2_full_pc_stall", {31'b0, pc_stall}, 32'd1);
         chk("t2_full_addr", imem_req_addr, 32'h8);
         chk("t2_full_head", id_pc, 32'h0);
         adv();
      end
      id_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (imem_req_valid && imem_req_ready) begin
            found = 1'b1;
            chk("t2_resume_addr", imem_req_addr, 32'h8);
         end
         adv();
         if (found) break;
      end
      chk("t2_resume_fired", {31'b0, found}, 32'd1);
      run(6);

      // 3: flush while WAIT, slow response dropped
      id_ready = 1'b1; lat = 3;
      do_reset(32'h10);
      @(negedge clk);
      chk("t3_fire_addr", imem_req_addr, 32'h10);
      chk("t3_fire_valid", {31'b0, imem_req_valid}, 32'd1);
      adv();
      flush = 1'b1; flush_tgt = 32'h100;
      @(negedge clk);
      chk("t3_flush_no_req", {31'b0, imem_req_valid}, 32'd0);
      adv();
      @(negedge clk);
      chk("t3_drop_no_req", {31'b0, imem_req_valid}, 32'd0);
      chk("t3_drop_stall", {31'b0, pc_stall}, 32'd1);
      adv();
      @(negedge clk);
      chk("t3_dropresp_no_req", {31'b0, imem_req_valid}, 32'd0);
      lat = 1;
      adv();
      @(negedge clk);
      chk("t3_new_req_valid", {31'b0, imem_req_valid}, 32'd1);
      chk("t3_new_req_addr", imem_req_addr, 32'h100);
      adv();
      found = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (id_valid && !found) begin
            found = 1'b1;
            chk("t3_id_pc", id_pc, 32'h100);
            chk("t3_id_inst", id_inst, mdata(32'h100));
         end
         adv();
         if (found) break;
      end
      chk("t3_delivered", {31'b0, found}, 32'd1);
      run(4);

      // 4: flush coincident with a response, one entry queued
      id_ready = 1'b0; lat = 1;
      do_reset(32'h0);
      run(2);
      flush = 1'b1; flush_tgt = 32'h200;
      @(negedge clk);
      chk("t4_pre_id_valid", {31'b0, id_valid}, 32'd1);
      chk("t4_resp_present", {31'b0, imem_resp_valid}, 32'd1);
      chk("t4_flush_no_req", {31'b0, imem_req_valid}, 32'd0);
      adv();
      @(negedge clk);
      chk("t4_post_id_valid", {31'b0, id_valid}, 32'd0);
      chk("t4_post_req_valid", {31'b0, imem_req_valid}, 32'd1);
      chk("t4_post_req_addr", imem_req_addr, 32'h200);
      adv();
      id_ready = 1'b1;
      run(6);

      // 5: memory back-pressure
      id_ready = 1'b1; lat = 1; imem_req_ready = 1'b0;
      do_reset(32'h40);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t5_hold_valid", {31'b0, imem_req_valid}, 32'd1);
         chk("t5_hold_addr", imem_req_addr, 32'h40);
         chk("t5_hold_stall", {31'b0, pc_stall}, 32'd1);
         adv();
      end
      imem_req_ready = 1'b1;
      @(negedge clk);
      chk("t5_fire_valid", {31'b0, imem_req_valid}, 32'd1);
      chk("t5_fire_addr", imem_req_addr, 32'h40);
      chk("t5_fire_stall", {31'b0, pc_stall}, 32'd0);
      adv();
      run(6);

      // 6: asynchronous reset mid-WAIT, then a stray response in IDLE
      id_ready = 1'b0; lat = 1;
      do_reset(32'h0);
      @(negedge clk);
      adv();
      lat = 6;
      @(negedge clk);
      adv();
      @(negedge clk);
      chk("t6_pre_id_valid", {31'b0, id_valid}, 32'd1);
      chk("t6_pre_wait_no_req", {31'b0, imem_req_valid}, 32'd0);
      #2;
      rst = 1'b0;
      #1;
      chk("t6_async_id_valid", {31'b0, id_valid}, 32'd0);
      chk("t6_async_req_valid", {31'b0, imem_req_valid}, 32'd0);
      chk("t6_async_pc_stall", {31'b0, pc_stall}, 32'd1);
      chk("t6_async_id_pc", id_pc, 32'h0);
      chk("t6_async_id_inst", id_inst, 32'h0);
      lat = 1;
      do_reset(32'h80);
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'hDEADBEEF;
      cur_drop        = 1'b1;
      @(negedge clk);
      adv();
      @(negedge clk);
      chk("t6_stray_ignored", {31'b0, id_valid}, 32'd0);
      chk("t6_stray_req_addr", imem_req_addr, 32'h80);
      adv();
      imem_req_ready = 1'b1;
      id_ready = 1'b1;
      run(6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
